// File: rtl/gemm_operand_loader.sv
// -----------------------------------------------------------------------------
// gemm_operand_loader
//
// Purpose:
//   Writer side of the GeMM operand SRAMs. A host/DMA first presents the matrix
//   sizes (M, K, N) on a valid/ready configuration handshake. It then streams
//   the elements of A (row-major, M*K elements) followed by the elements of
//   B (row-major, K*N elements). The loader writes them into SRAM A and
//   SRAM B, pulses gemm_start_o to the accelerator, waits for gemm_done_i and
//   finally reports done_o.
//
// Ports:
//   clk_i, rst_i            clock (rising edge) and synchronous active-high reset
//   cfg_valid_i/ready_o     size configuration handshake (ready only in IDLE)
//   M/K/N_size_i            requested matrix sizes
//   s_data_i/valid_i/ready_o element stream (ready only while loading)
//   sram_a_*_o, sram_b_*_o  registered SRAM write ports (addr, wdata, we)
//   M/K/N_size_o            sizes latched at the last configuration accept
//   gemm_start_o            one-cycle start pulse to the accelerator
//   gemm_done_i             accelerator done pulse (only honoured in WAIT)
//   busy_o                  high in every state except IDLE
//   done_o                  one-cycle completion pulse
//   err_o                   one-cycle pulse when a zero size is rejected
// -----------------------------------------------------------------------------
module gemm_operand_loader #(
  parameter int InDataWidth   = 8,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // Size configuration
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  // Element stream
  input  logic [InDataWidth-1:0]   s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  // SRAM A write port
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [InDataWidth-1:0]   sram_a_wdata_o,
  output logic                     sram_a_we_o,
  // SRAM B write port
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [InDataWidth-1:0]   sram_b_wdata_o,
  output logic                     sram_b_we_o,
  // Accelerator interface
  output logic [SizeAddrWidth-1:0] M_size_o,
  output logic [SizeAddrWidth-1:0] K_size_o,
  output logic [SizeAddrWidth-1:0] N_size_o,
  output logic                     gemm_start_o,
  input  logic                     gemm_done_i,
  // Status
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  // Element counters and limits are twice the size-field width so that the
  // full product of two size fields is representable.
  localparam int CntWidth = 2 * SizeAddrWidth;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [SizeAddrWidth-1:0] m_size_q, m_size_d;
  logic [SizeAddrWidth-1:0] k_size_q, k_size_d;
  logic [SizeAddrWidth-1:0] n_size_q, n_size_d;

  logic start_q, start_d;
  logic done_q,  done_d;
  logic err_q,   err_d;

  logic cfg_accept;
  logic accept;
  logic size_zero;

  // Per-operand views: index 0 is operand A, index 1 is operand B.
  logic [1:0]                    op_active;
  logic [1:0]                    op_accept;
  logic [1:0]                    op_last;
  logic [1:0]                    op_we;
  logic [1:0][AddrWidth-1:0]     op_addr;
  logic [1:0][InDataWidth-1:0]   op_wdata;
  logic [1:0][SizeAddrWidth-1:0] op_rows;
  logic [1:0][SizeAddrWidth-1:0] op_cols;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign cfg_ready_o = (state_q == IDLE);
  assign cfg_accept  = cfg_valid_i && cfg_ready_o;
  assign size_zero   = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);

  assign s_ready_o = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept    = s_valid_i && s_ready_o;

  // A is M x K, B is K x N.
  assign op_rows = {K_size_i, M_size_i};
  assign op_cols = {N_size_i, K_size_i};

  // ---------------------------------------------------------------------------
  // Operand write paths (A and B are structurally identical)
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic [CntWidth-1:0]    cnt_q,   cnt_d;
    logic [CntWidth-1:0]    lim_q,   lim_d;
    logic                   we_q,    we_d;
    logic [AddrWidth-1:0]   addr_q,  addr_d;
    logic [InDataWidth-1:0] wdata_q, wdata_d;

    assign op_active[gi] = (gi == 0) ? (state_q == LOAD_A) : (state_q == LOAD_B);
    assign op_accept[gi] = accept && op_active[gi];
    // Limits are never zero while loading (zero sizes are rejected in IDLE).
    assign op_last[gi]   = (cnt_q == (lim_q - CntWidth'(1)));

    always_comb begin
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (cfg_accept) begin
        // Product at full counter width: 255*255 must not wrap.
        lim_d = CntWidth'(op_rows[gi]) * CntWidth'(op_cols[gi]);
        cnt_d = '0;
      end else if (op_accept[gi]) begin
        // Write issues the cycle after the accept, with the element as captured.
        we_d    = 1'b1;
        addr_d  = AddrWidth'(cnt_q);
        wdata_d = s_data_i;
        cnt_d   = op_last[gi] ? '0 : (cnt_q + CntWidth'(1));
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q   <= '0;
        lim_q   <= '0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
      end else begin
        cnt_q   <= cnt_d;
        lim_q   <= lim_d;
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
      end
    end

    assign op_we[gi]    = we_q;
    assign op_addr[gi]  = addr_q;
    assign op_wdata[gi] = wdata_q;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    m_size_d = m_size_q;
    k_size_d = k_size_q;
    n_size_d = n_size_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_accept) begin
          // Sizes are latched even when rejected so the accelerator-facing
          // outputs always reflect the most recent configuration.
          m_size_d = M_size_i;
          k_size_d = K_size_i;
          n_size_d = N_size_i;
          if (size_zero) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        // No bubble: the element after the last A element is already B's first.
        if (op_accept[0] && op_last[0]) begin
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (op_accept[1] && op_last[1]) begin
          state_d = START;
        end
      end
      START: begin
        // Registered start lands one cycle after the final B write is on the bus.
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (gemm_done_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      m_size_q <= '0;
      k_size_q <= '0;
      n_size_q <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_size_q <= m_size_d;
      k_size_q <= k_size_d;
      n_size_q <= n_size_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sram_a_we_o    = op_we[0];
  assign sram_a_addr_o  = op_addr[0];
  assign sram_a_wdata_o = op_wdata[0];
  assign sram_b_we_o    = op_we[1];
  assign sram_b_addr_o  = op_addr[1];
  assign sram_b_wdata_o = op_wdata[1];

  assign M_size_o     = m_size_q;
  assign K_size_o     = k_size_q;
  assign N_size_o     = n_size_q;
  assign gemm_start_o = start_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_gemm_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_gemm_operand_loader
//
// Self-checking bench for gemm_operand_loader. A transaction-level model runs
// at every falling edge: it tracks which stream element index is accepted and
// derives the SRAM write (operand, address, data) and the start/done/err
// pulses from the matrix sizes. A table of configurations is applied and its
// per-run totals compared; hand-written sequences cover data placement, the
// reset-mid-load case and a batch of random configurations.
// -----------------------------------------------------------------------------
module tb_gemm_operand_loader;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [SW-1:0] M_size_i, K_size_i, N_size_i;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [AW-1:0] sram_a_addr_o, sram_b_addr_o;
  logic [DW-1:0] sram_a_wdata_o, sram_b_wdata_o;
  logic          sram_a_we_o, sram_b_we_o;
  logic [SW-1:0] M_size_o, K_size_o, N_size_o;
  logic          gemm_start_o;
  logic          gemm_done_i;
  logic          busy_o, done_o, err_o;

  always #5 clk = ~clk;

  gemm_operand_loader #(
    .InDataWidth  (DW),
    .AddrWidth    (AW),
    .SizeAddrWidth(SW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .M_size_i      (M_size_i),
    .K_size_i      (K_size_i),
    .N_size_i      (N_size_i),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .sram_a_addr_o (sram_a_addr_o),
    .sram_a_wdata_o(sram_a_wdata_o),
    .sram_a_we_o   (sram_a_we_o),
    .sram_b_addr_o (sram_b_addr_o),
    .sram_b_wdata_o(sram_b_wdata_o),
    .sram_b_we_o   (sram_b_we_o),
    .M_size_o      (M_size_o),
    .K_size_o      (K_size_o),
    .N_size_o      (N_size_o),
    .gemm_start_o  (gemm_start_o),
    .gemm_done_i   (gemm_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model state ----------------
  int      ncyc = 0;
  bit      armed = 1'b0;
  bit      m_active = 1'b0, m_loading = 1'b0, m_waiting = 1'b0;
  bit      acc_prev = 1'b0, exp_done_next = 1'b0, exp_err_next = 1'b0;
  int      m_mk = 0, m_total = 0, acc_cnt = 0, acc_j = 0;
  int      exp_start_ncyc = -10;
  logic [DW-1:0] acc_data = '0;
  logic [SW-1:0] m_m = '0, m_k = '0, m_n = '0;
  logic [AW-1:0] last_a_addr = '0, last_b_addr = '0;
  logic [DW-1:0] last_a_data = '0, last_b_data = '0;

  // ---------------- observations of the DUT ----------------
  int obs_na = 0, obs_nb = 0, obs_start = 0, obs_done = 0, obs_err = 0;
  int obs_last_a = 0, obs_last_b = 0;
  logic [DW-1:0] sh_a [int];
  logic [DW-1:0] sh_b [int];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, ncyc);
    end
  endfunction

  // One model step per falling edge: first compare what the DUT shows now,
  // then predict the effect of the inputs that the next rising edge samples.
  function automatic void mon_step();
    if (armed) begin
      if (acc_prev) begin
        if (acc_j < m_mk) begin
          chk("a_we",    32'(sram_a_we_o), 32'(1));
          chk("a_addr",  32'(sram_a_addr_o), 32'(acc_j));
          chk("a_wdata", 32'(sram_a_wdata_o), 32'(acc_data));
          chk("b_we_quiet", 32'(sram_b_we_o), 32'(0));
          last_a_addr = AW'(acc_j);
          last_a_data = acc_data;
        end else begin
          chk("b_we",    32'(sram_b_we_o), 32'(1));
          chk("b_addr",  32'(sram_b_addr_o), 32'(acc_j - m_mk));
          chk("b_wdata", 32'(sram_b_wdata_o), 32'(acc_data));
          chk("a_we_quiet", 32'(sram_a_we_o), 32'(0));
          last_b_addr = AW'(acc_j - m_mk);
          last_b_data = acc_data;
        end
      end else begin
        chk("a_we_idle",     32'(sram_a_we_o), 32'(0));
        chk("b_we_idle",     32'(sram_b_we_o), 32'(0));
        chk("a_addr_hold",   32'(sram_a_addr_o), 32'(last_a_addr));
        chk("a_wdata_hold",  32'(sram_a_wdata_o), 32'(last_a_data));
        chk("b_addr_hold",   32'(sram_b_addr_o), 32'(last_b_addr));
        chk("b_wdata_hold",  32'(sram_b_wdata_o), 32'(last_b_data));
      end
      chk("gemm_start", 32'(gemm_start_o), 32'(ncyc == exp_start_ncyc));
      chk("done",       32'(done_o), 32'(exp_done_next));
      chk("err",        32'(err_o), 32'(exp_err_next));
      chk("busy",       32'(busy_o), 32'(m_active));
      chk("cfg_ready",  32'(cfg_ready_o), 32'(!m_active));
      chk("s_ready",    32'(s_ready_o), 32'(m_loading));
      chk("M_size_o",   32'(M_size_o), 32'(m_m));
      chk("K_size_o",   32'(K_size_o), 32'(m_k));
      chk("N_size_o",   32'(N_size_o), 32'(m_n));
    end

    if (sram_a_we_o === 1'b1) begin
      obs_na++;
      obs_last_a = int'(sram_a_addr_o);
      sh_a[int'(sram_a_addr_o)] = sram_a_wdata_o;
    end
    if (sram_b_we_o === 1'b1) begin
      obs_nb++;
      obs_last_b = int'(sram_b_addr_o);
      sh_b[int'(sram_b_addr_o)] = sram_b_wdata_o;
    end
    if (gemm_start_o === 1'b1) obs_start++;
    if (done_o === 1'b1) obs_done++;
    if (err_o === 1'b1) obs_err++;

    // The accelerator is being waited on from the start-pulse cycle onward.
    if (ncyc == exp_start_ncyc) m_waiting = 1'b1;

    acc_prev      = 1'b0;
    exp_done_next = 1'b0;
    exp_err_next  = 1'b0;
    if (rst_i) begin
      armed          = 1'b1;
      m_active       = 1'b0;
      m_loading      = 1'b0;
      m_waiting      = 1'b0;
      exp_start_ncyc = -10;
      m_m = '0; m_k = '0; m_n = '0;
      last_a_addr = '0; last_b_addr = '0;
      last_a_data = '0; last_b_data = '0;
    end else if (!m_active) begin
      if (cfg_valid_i) begin
        m_m = M_size_i; m_k = K_size_i; m_n = N_size_i;
        if (M_size_i == 0 || K_size_i == 0 || N_size_i == 0) begin
          exp_err_next = 1'b1;
        end else begin
          m_active  = 1'b1;
          m_loading = 1'b1;
          m_mk      = int'(M_size_i) * int'(K_size_i);
          m_total   = m_mk + int'(K_size_i) * int'(N_size_i);
          acc_cnt   = 0;
        end
      end
    end else if (m_loading) begin
      if (s_valid_i) begin
        acc_prev = 1'b1;
        acc_j    = acc_cnt;
        acc_data = s_data_i;
        acc_cnt++;
        if (acc_cnt == m_total) begin
          m_loading      = 1'b0;
          exp_start_ncyc = ncyc + 2;
        end
      end
    end else if (m_waiting && gemm_done_i) begin
      exp_done_next = 1'b1;
      m_active      = 1'b0;
      m_waiting     = 1'b0;
    end
    ncyc++;
  endfunction

  // Advance one clock: model at the falling edge, then return 1 time unit
  // after the rising edge, where the driver applies new inputs.
  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 = valid held high (data idx+1), 1 = valid toggling, 2 = random.
  task automatic run_cfg(input int m, input int k, input int n, input int vmode,
                         input int dly, input bit early);
    int  total, idx, guard;
    bit  acc;
    cfg_valid_i = 1'b1;
    M_size_i = SW'(m); K_size_i = SW'(k); N_size_i = SW'(n);
    tick();
    cfg_valid_i = 1'b0;
    if (m == 0 || k == 0 || n == 0) begin
      repeat (3) tick();
      return;
    end
    total = m * k + k * n;
    idx   = 0;
    guard = 0;
    while (idx < total) begin
      case (vmode)
        0:       s_valid_i = 1'b1;
        1:       s_valid_i = ~s_valid_i;
        default: s_valid_i = 1'($urandom_range(0, 1));
      endcase
      s_data_i    = (vmode == 0) ? DW'(idx + 1) : DW'($urandom);
      gemm_done_i = early && (idx == 1);
      acc = s_valid_i && s_ready_o;
      tick();
      if (acc) begin
        idx++;
        guard = 0;
      end else begin
        guard++;
        if (guard > 64) begin
          chk("stream_timeout", 32'(idx), 32'(total));
          break;
        end
      end
    end
    s_valid_i   = 1'b0;
    gemm_done_i = 1'b0;
    guard = 0;
    while (gemm_start_o !== 1'b1 && guard < 8) begin
      tick();
      guard++;
    end
    chk("start_seen", 32'(gemm_start_o), 32'(1));
    repeat (dly) tick();
    gemm_done_i = 1'b1;
    tick();
    gemm_done_i = 1'b0;
    chk("done_pulse", 32'(done_o), 32'(1));
    chk("busy_after_done", 32'(busy_o), 32'(0));
    chk("cfg_ready_after_done", 32'(cfg_ready_o), 32'(1));
    tick();
  endtask

  typedef struct {
    int m, k, n, vmode, dly;
    bit early;
    int exp_err, exp_na, exp_nb, exp_last_a, exp_last_b, exp_start, exp_done;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int e0, a0, b0, s0, d0;
    rst_i = 1'b1; cfg_valid_i = 1'b0;
    M_size_i = '0; K_size_i = '0; N_size_i = '0;
    s_data_i = '0; s_valid_i = 1'b0; gemm_done_i = 1'b0;

    //          m    k    n  vm dly early err  na     nb   lastA  lastB st dn
    tbl[0] = '{  2,   3,   4, 0, 20, 1'b0, 0,     6,  12,     5,   11, 1, 1};
    tbl[1] = '{  2,   0,   4, 0,  0, 1'b0, 1,     0,   0,     0,    0, 0, 0};
    tbl[2] = '{  1,   1,   1, 1,  2, 1'b0, 0,     1,   1,     0,    0, 1, 1};
    tbl[3] = '{  0,   5,   5, 0,  0, 1'b0, 1,     0,   0,     0,    0, 0, 0};
    tbl[4] = '{  3,   5,   2, 2,  3, 1'b1, 0,    15,  10,    14,    9, 1, 1};
    tbl[5] = '{  7,   1,   9, 2,  0, 1'b0, 0,     7,   9,     6,    8, 1, 1};
    tbl[6] = '{  4,   4,   0, 0,  0, 1'b0, 1,     0,   0,     0,    0, 0, 0};
    tbl[7] = '{ 20,  20,   1, 0,  1, 1'b1, 0,   400,  20,   399,   19, 1, 1};
    tbl[8] = '{255, 255,   1, 0,  2, 1'b1, 0, 65025, 255, 65024,  254, 1, 1};

    repeat (3) tick();
    rst_i = 1'b0;

    // Reset state
    chk("rst_a_we", 32'(sram_a_we_o), 32'(0));
    chk("rst_b_we", 32'(sram_b_we_o), 32'(0));
    chk("rst_start", 32'(gemm_start_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_s_ready", 32'(s_ready_o), 32'(0));
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'(1));
    chk("rst_sizes", 32'({M_size_o, K_size_o, N_size_o}), 32'(0));

    for (int i = 0; i < 9; i++) begin
      e0 = obs_err; a0 = obs_na; b0 = obs_nb; s0 = obs_start; d0 = obs_done;
      run_cfg(tbl[i].m, tbl[i].k, tbl[i].n, tbl[i].vmode, tbl[i].dly, tbl[i].early);
      chk("tbl_err",    32'(obs_err - e0),   32'(tbl[i].exp_err));
      chk("tbl_a_wr",   32'(obs_na - a0),    32'(tbl[i].exp_na));
      chk("tbl_b_wr",   32'(obs_nb - b0),    32'(tbl[i].exp_nb));
      chk("tbl_start",  32'(obs_start - s0), 32'(tbl[i].exp_start));
      chk("tbl_done",   32'(obs_done - d0),  32'(tbl[i].exp_done));
      if (tbl[i].exp_na > 0) chk("tbl_last_a", 32'(obs_last_a), 32'(tbl[i].exp_last_a));
      if (tbl[i].exp_nb > 0) chk("tbl_last_b", 32'(obs_last_b), 32'(tbl[i].exp_last_b));
      $display("vec %0d M=%0d K=%0d N=%0d a_writes=%0d b_writes=%0d err=%0d start=%0d done=%0d",
               i, tbl[i].m, tbl[i].k, tbl[i].n, obs_na - a0, obs_nb - b0,
               obs_err - e0, obs_start - s0, obs_done - d0);
    end

    // Data placement for M=2,K=3,N=4 with elements 1..18.
    sh_a.delete(); sh_b.delete();
    run_cfg(2, 3, 4, 0, 20, 1'b0);
    for (int i = 0; i < 6; i++)
      chk("t1_a_data", sh_a.exists(i) ? 32'(sh_a[i]) : 32'hFFFF_FFFF, 32'(i + 1));
    for (int i = 0; i < 12; i++)
      chk("t1_b_data", sh_b.exists(i) ? 32'(sh_b[i]) : 32'hFFFF_FFFF, 32'(i + 7));
    $display("seq t1 data placement checked, a_entries=%0d b_entries=%0d", sh_a.num(), sh_b.num());

    // Reset while element 4 of A is presented, then a clean reload.
    cfg_valid_i = 1'b1; M_size_i = 8'd4; K_size_i = 8'd4; N_size_i = 8'd4;
    tick();
    cfg_valid_i = 1'b0;
    for (int e = 0; e < 4; e++) begin
      s_valid_i = 1'b1;
      s_data_i  = DW'(8'hA0 + e);
      tick();
    end
    s_valid_i = 1'b1; s_data_i = 8'hA4; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; s_valid_i = 1'b0;
    chk("t5_a_we",    32'(sram_a_we_o), 32'(0));
    chk("t5_a_addr",  32'(sram_a_addr_o), 32'(0));
    chk("t5_a_wdata", 32'(sram_a_wdata_o), 32'(0));
    chk("t5_busy",    32'(busy_o), 32'(0));
    chk("t5_s_ready", 32'(s_ready_o), 32'(0));
    chk("t5_pulses",  32'({gemm_start_o, done_o, err_o}), 32'(0));
    chk("t5_sizes",   32'({M_size_o, K_size_o, N_size_o}), 32'(0));
    chk("t5_cfg_ready", 32'(cfg_ready_o), 32'(1));
    sh_a.delete(); sh_b.delete();
    run_cfg(4, 4, 4, 0, 1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("t5_a_data", sh_a.exists(i) ? 32'(sh_a[i]) : 32'hFFFF_FFFF, 32'(i + 1));
      chk("t5_b_data", sh_b.exists(i) ? 32'(sh_b[i]) : 32'hFFFF_FFFF, 32'(i + 17));
    end
    $display("seq t5 reset mid-load and reload checked");

    // Random configurations and stall patterns.
    for (int r = 0; r < 12; r++) begin
      int rm, rk, rn, rd;
      bit re;
      rm = int'($urandom_range(0, 5));
      rk = int'($urandom_range(0, 5));
      rn = int'($urandom_range(0, 5));
      rd = int'($urandom_range(0, 10));
      re = 1'($urandom_range(0, 1));
      a0 = obs_na; b0 = obs_nb;
      run_cfg(rm, rk, rn, 2, rd, re);
      $display("rand %0d M=%0d K=%0d N=%0d done_delay=%0d a_writes=%0d b_writes=%0d",
               r, rm, rk, rn, rd, obs_na - a0, obs_nb - b0);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
